// File: rtl/thread_sched_pkg.sv
// Shared definitions for the two-thread dispatch scheduler: address/ROB widths,
// thread lifecycle states and the per-thread slot computation.
`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef ROB_BITS
`define ROB_BITS 5
`endif

package thread_sched_pkg;

  localparam int ADDR_BITS      = `ADDR_BITS;
  localparam int NUM_THREADS    = 2;
  localparam int DISPATCH_WIDTH = 2;

  typedef enum logic [1:0] {
    TS_IDLE    = 2'd0,
    TS_RUN     = 2'd1,
    TS_RECOVER = 2'd2,
    TS_HALTED  = 2'd3
  } thread_state_t;

  // Slots a thread may take this cycle: its ROB headroom clipped to what fetch has ready.
  function automatic logic [1:0] thread_slots(
    input logic       running,
    input logic       full,
    input logic       almost_full,
    input logic [1:0] avail
  );
    logic [1:0] cap;
    if (!running || full) cap = 2'd0;
    else if (almost_full) cap = 2'd1;
    else                  cap = 2'(DISPATCH_WIDTH);
    return (avail < cap) ? avail : cap;
  endfunction

endpackage

// File: rtl/thread_sched.sv
// Two-thread dispatch arbiter with per-thread lifecycle FSMs (run, nuke recovery,
// halt, fork-spawn) and a round-robin tie breaker on equal ROB occupancy.
module thread_sched
  import thread_sched_pkg::*;
#(
  parameter int ROB_BITS       = `ROB_BITS,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_THREADS-1:0][ROB_BITS:0]    rob_count,
  input  logic [NUM_THREADS-1:0]                rob_full,
  input  logic [NUM_THREADS-1:0]                rob_almost_full,
  input  logic [NUM_THREADS-1:0]                rob_halt,
  input  logic [NUM_THREADS-1:0]                rob_nuke,
  input  logic [NUM_THREADS-1:0]                rob_fork_committed,
  input  logic [NUM_THREADS-1:0][ADDR_BITS-1:0] rob_fork_addr,
  input  logic [NUM_THREADS-1:0][1:0]           inst_avail,
  output logic                                  disp_thread_ID,
  output logic [1:0]                            disp_count,
  output logic [NUM_THREADS-1:0]                thread_active,
  output logic                                  start_valid,
  output logic                                  start_thread_ID,
  output logic [ADDR_BITS-1:0]                  start_pc,
  output logic                                  fork_dropped,
  output logic                                  all_halted
);

  localparam int CNT_W = (RECOVER_CYCLES < 2) ? 1 : $clog2(RECOVER_CYCLES + 1);

  thread_state_t              state_q   [NUM_THREADS];
  thread_state_t              state_nxt [NUM_THREADS];
  logic [CNT_W-1:0]           cnt_q     [NUM_THREADS];
  logic [CNT_W-1:0]           cnt_nxt   [NUM_THREADS];
  logic                       rr_ptr_q;
  logic                       rr_ptr_nxt;
  logic [NUM_THREADS-1:0]     start_req;
  logic                       drop_nxt;
  logic [NUM_THREADS-1:0][1:0] slots;

  // A fork only lands on a dormant sibling, and never when both threads fork at once.
  assign start_req[0] = rob_fork_committed[1] & ~rob_fork_committed[0] & ~thread_active[0];
  assign start_req[1] = rob_fork_committed[0] & ~rob_fork_committed[1] & ~thread_active[1];
  assign drop_nxt     = (rob_fork_committed[0] & rob_fork_committed[1])
                      | (rob_fork_committed[0] & thread_active[1])
                      | (rob_fork_committed[1] & thread_active[0]);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q[0]      <= TS_RUN;
      state_q[1]      <= TS_IDLE;
      cnt_q[0]        <= '0;
      cnt_q[1]        <= '0;
      rr_ptr_q        <= 1'b0;
      start_valid     <= 1'b0;
      start_thread_ID <= 1'b0;
      start_pc        <= '0;
      fork_dropped    <= 1'b0;
      all_halted      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      for (int t = 0; t < NUM_THREADS; t++) begin
        state_q[t] <= state_nxt[t];
        cnt_q[t]   <= cnt_nxt[t];
      end
      rr_ptr_q     <= rr_ptr_nxt;
      start_valid  <= |start_req;
      if (|start_req) begin
        start_thread_ID <= start_req[1];
        start_pc        <= start_req[1] ? rob_fork_addr[0] : rob_fork_addr[1];
      end
      fork_dropped <= drop_nxt;
      all_halted   <= (state_nxt[0] == TS_HALTED)
                    && (state_nxt[1] != TS_RUN) && (state_nxt[1] != TS_RECOVER);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic, one FSM per thread
  // ---------------------------------------------------------------------------
  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thread
    always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      state_nxt[t] = state_q[t];
      cnt_nxt[t]   = cnt_q[t];
      unique case (state_q[t])
        TS_RUN, TS_RECOVER: begin
          if (rob_halt[t]) begin
            state_nxt[t] = TS_HALTED;
            cnt_nxt[t]   = '0;
          end else if (rob_nuke[t]) begin
            state_nxt[t] = TS_RECOVER;
            cnt_nxt[t]   = CNT_W'(RECOVER_CYCLES);
          end else if (state_q[t] == TS_RECOVER) begin
            // Leave recovery on the edge where the counter would reach zero.
            if (cnt_q[t] <= CNT_W'(1)) begin
              state_nxt[t] = TS_RUN;
              cnt_nxt[t]   = '0;
            end else begin
              cnt_nxt[t]   = cnt_q[t] - CNT_W'(1);
            end
          end
        end
        default: begin
          if (start_req[t]) state_nxt[t] = TS_RUN;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: activity flags and dispatch arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    thread_active = '0;
    slots         = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      thread_active[t] = (state_q[t] == TS_RUN) || (state_q[t] == TS_RECOVER);
      slots[t] = thread_slots(state_q[t] == TS_RUN, rob_full[t], rob_almost_full[t],
                              inst_avail[t]);
    end
  end

  always_comb begin
    disp_thread_ID = 1'b0;
    disp_count     = 2'd0;
    rr_ptr_nxt     = rr_ptr_q;
    unique case ({slots[1] != 2'd0, slots[0] != 2'd0})
      2'b01: begin
        disp_thread_ID = 1'b0;
        disp_count     = slots[0];
      end
      2'b10: begin
        disp_thread_ID = 1'b1;
        disp_count     = slots[1];
      end
      2'b11: begin
        // Favour the emptier ROB; only a true tie consults and flips the pointer.
        if (rob_count[0] < rob_count[1]) begin
          disp_thread_ID = 1'b0;
        end else if (rob_count[1] < rob_count[0]) begin
          disp_thread_ID = 1'b1;
        end else begin
          disp_thread_ID = rr_ptr_q;
          rr_ptr_nxt     = ~rr_ptr_q;
        end
        disp_count = disp_thread_ID ? slots[1] : slots[0];
      end
      default: ;
    endcase
  end

endmodule

// File: doc/thread_sched.md
THREAD_SCHED -- requirements
Module: thread_sched

Interface
REQ-001 SHALL have parameter ROB_BITS, default `ROB_BITS, meaning ROB index width; per-thread occupancy is ROB_BITS+1 bits.
REQ-002 SHALL have parameter RECOVER_CYCLES, default 2, meaning dead cycles after a non-halt nuke before the thread dispatches again.
REQ-003 SHALL have port clock  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset; state clears while reset==0.
REQ-005 SHALL have port rob_count[t]  in  ROB_BITS+1  occupancy of thread t ROB (t=0,1).
REQ-006 SHALL have port rob_full[t], rob_almost_full[t]  in  1 each  ROB capacity flags.
REQ-007 SHALL have port rob_halt[t], rob_nuke[t]  in  1 each  ROB commit-side pulses.
REQ-008 SHALL have port rob_fork_committed[t]  in  1, and rob_fork_addr[t]  in  `ADDR_BITS  fork commit pulse and target.
REQ-009 SHALL have port inst_avail[t]  in  2  fetched instructions ready for thread t (0..2).
REQ-010 SHALL have port disp_thread_ID  out  1  thread granted this cycle.
REQ-011 SHALL have port disp_count  out  2  dispatch slots granted (0..2); 0 means no dispatch.
REQ-012 SHALL have port thread_active  out  2  per-thread state is RUN or RECOVER.
REQ-013 SHALL have port start_valid, start_thread_ID, start_pc  out  1/1/`ADDR_BITS  registered one-cycle fetch redirect for a spawned thread.
REQ-014 SHALL have port fork_dropped  out  1  registered pulse: a fork was discarded.
REQ-015 SHALL have port all_halted  out  1  registered: processor finished.

Function
REQ-016 SHALL keep per-thread state IDLE, RUN, RECOVER, HALTED, plus a 1-bit round-robin pointer and a per-thread recovery counter.
REQ-017 SHALL move a thread RUN/RECOVER->HALTED on rob_halt[t]; halt has priority over rob_nuke[t] in the same cycle.
REQ-018 SHALL move RUN->RECOVER on rob_nuke[t] without halt, load counter to RECOVER_CYCLES, and move to RUN when the counter reaches 0.
REQ-019 SHALL, on a nuke during RECOVER, reload the counter.
REQ-020 SHALL, on rob_fork_committed[t], move the other thread IDLE/HALTED->RUN and pulse start_valid, start_thread_ID=other, start_pc=rob_fork_addr[t] next cycle.
REQ-021 SHALL drop the fork and pulse fork_dropped when the other thread is RUN or RECOVER.
REQ-022 SHALL honour a same-cycle fork and halt from thread t: t->HALTED, other thread started.
REQ-023 SHALL drop both forks, with a single fork_dropped pulse, when both threads fork in the same cycle.
REQ-024 SHALL compute disp_count and disp_thread_ID combinationally from registered state and current inputs.
REQ-025 SHALL set cap[t]=0 if rob_full[t] or state!=RUN, 1 if rob_almost_full[t], else 2, and slots[t]=min(cap[t], inst_avail[t]).
REQ-026 SHALL treat thread t as eligible iff slots[t]>0.
REQ-027 SHALL grant a lone eligible thread its slots[t].
REQ-028 SHALL, when both are eligible, grant the thread with the smaller rob_count, and on a tie the thread named by the pointer.
REQ-029 SHALL invert the pointer only on a tie-broken grant, to point at the loser.
REQ-030 SHALL drive disp_count=0 and disp_thread_ID=0 when no thread is eligible.
REQ-031 SHALL assert all_halted when thread 0 is HALTED and thread 1 is IDLE or HALTED; it is sticky until a fork restarts a thread.

Reset
REQ-032 SHALL, during reset, set thread 0 to RUN, thread 1 to IDLE, pointer=0, counters=0.
REQ-033 SHALL, during reset, drive start_valid=0, start_thread_ID=0, start_pc=0, fork_dropped=0, all_halted=0, and thread_active=2'b01.
REQ-034 SHALL, when reset is asserted mid-RECOVER or mid-fork, abandon the operation immediately with no start_valid pulse after release.

Structure
REQ-035 SHALL place the thread-state enum, `ADDR_BITS and `ROB_BITS in the shared package alongside DISPATCH_ROB/CDB.
REQ-036 SHALL be a single module with per-thread FSM logic in a generate loop; no sub-module.

Verification
REQ-037 Scenario: reset release, inst_avail[0]=2, ROB0 empty -> disp_thread_ID=0, disp_count=2; thread_active=01.
REQ-038 Scenario: rob_fork_committed[0] with addr 0x40 -> next cycle start_valid=1, start_thread_ID=1, start_pc=0x40; thread_active=11.
REQ-039 Scenario: both RUN, rob_count 5/5, avail 2/2 for 4 cycles -> grants alternate 0,1,0,1.
REQ-040 Scenario: rob_count 3/9 -> thread 0 granted; rob_almost_full[0]=1 -> disp_count=1.
REQ-041 Scenario: rob_nuke[1] -> thread 1 gets 0 slots for 2 cycles, then is granted again.
REQ-042 Scenario: rob_halt[1] then rob_halt[0] -> all_halted=1 the cycle after the second halt; fork while thread 1 RUN -> fork_dropped=1.
